// File: rtl/pingpong_stream_buffer.sv
// Purpose: two-bank ping-pong word buffer; banks change hands only on commit (writer) and release (reader).
// Latency: 1 cycle read (registered rdData); writes visible to any read issued the cycle after the write.
// Backpressure: wrReady low while the writer's bank is still full; writes/commits then are dropped and flagged.
//
// Ports:
//   clock, reset                 sole clock, synchronous active-high reset
//   wrAddress/wrEnable/wrData    word write into the writer-owned bank
//   wrCommit/wrCount             hand writer bank to reader with its valid word count
//   wrReady, wrBank              writer owns an empty bank / which physical bank it is
//   rdAddress/rdData             1-cycle registered read from the reader-owned bank
//   rdValid, rdCount, rdBank     reader owns a full bank / its word count / which bank
//   rdRelease                    return the reader bank to the writer
//   errorClear/errorFlags        sticky {releaseErr, commitErr, writeDropErr}
module pingpong_stream_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wrAddress,
    input  logic                  wrEnable,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  wrCommit,
    input  logic [ADDR_WIDTH:0]   wrCount,
    output logic                  wrReady,
    input  logic [ADDR_WIDTH-1:0] rdAddress,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdValid,
    output logic [ADDR_WIDTH:0]   rdCount,
    input  logic                  rdRelease,
    output logic                  wrBank,
    output logic                  rdBank,
    input  logic                  errorClear,
    output logic [2:0]            errorFlags
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH:0]   count0;
    logic [ADDR_WIDTH:0]   count1;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [2:0]            error_flags;

    logic                  wr_ready;
    logic                  rd_valid;
    logic                  do_write;
    logic                  do_commit;
    logic                  do_release;
    logic [ADDR_WIDTH:0]   commit_count;
    logic [2:0]            error_events;

    // All outputs decode from registers only; no input reaches an output combinationally.
    assign wr_ready = ~full[wr_bank];
    assign rd_valid = full[rd_bank];

    assign wrReady    = wr_ready;
    assign rdValid    = rd_valid;
    assign wrBank     = wr_bank;
    assign rdBank     = rd_bank;
    assign rdData     = rd_data;
    assign errorFlags = error_flags;
    assign rdCount    = rd_valid ? (rd_bank ? count1 : count0) : '0;

    assign do_write   = wrEnable  & wr_ready;
    assign do_commit  = wrCommit  & wr_ready;
    assign do_release = rdRelease & rd_valid;

    // Counts above the bank depth are clamped to the depth.
    assign commit_count = (wrCount > DEPTH_CNT) ? DEPTH_CNT : wrCount;

    assign error_events = {rdRelease & ~rd_valid,
                           wrCommit  & ~wr_ready,
                           wrEnable  & ~wr_ready};

    // Storage is never cleared by reset. A write in a commit cycle uses the
    // pre-commit wr_bank, so it lands in the bank being handed over.
    always_ff @(posedge clock) begin
        if (!reset && do_write) begin
            mem[{wr_bank, wrAddress}] <= wrData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            count0      <= '0;
            count1      <= '0;
            rd_data     <= '0;
            error_flags <= 3'b000;
        end else begin
            // Read uses the pre-release rd_bank, so a read in a release cycle
            // still returns the bank being given back.
            rd_data <= mem[{rd_bank, rdAddress}];

            // Ownership invariant guarantees a legal commit and a legal release
            // in the same cycle touch different banks, so both apply.
            if (do_commit) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
                if (wr_bank) begin
                    count1 <= commit_count;
                end else begin
                    count0 <= commit_count;
                end
            end
            if (do_release) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end

            if (errorClear) begin
                error_flags <= 3'b000;
            end else begin
                error_flags <= error_flags | error_events;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_stream_buffer.sv
module tb_pingpong_stream_buffer;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Default-size instance (32-bit words, 256-word banks)
    logic        reset;
    logic [7:0]  wrAddress;
    logic        wrEnable;
    logic [31:0] wrData;
    logic        wrCommit;
    logic [8:0]  wrCount;
    logic        wrReady;
    logic [7:0]  rdAddress;
    logic [31:0] rdData;
    logic        rdValid;
    logic [8:0]  rdCount;
    logic        rdRelease;
    logic        wrBank;
    logic        rdBank;
    logic        errorClear;
    logic [2:0]  errorFlags;

    // Small instance (16-bit words, 16-word banks)
    logic        s_reset;
    logic [3:0]  s_wrAddress;
    logic        s_wrEnable;
    logic [15:0] s_wrData;
    logic        s_wrCommit;
    logic [4:0]  s_wrCount;
    logic        s_wrReady;
    logic [3:0]  s_rdAddress;
    logic [15:0] s_rdData;
    logic        s_rdValid;
    logic [4:0]  s_rdCount;
    logic        s_rdRelease;
    logic        s_wrBank;
    logic        s_rdBank;
    logic        s_errorClear;
    logic [2:0]  s_errorFlags;

    pingpong_stream_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .wrAddress(wrAddress), .wrEnable(wrEnable), .wrData(wrData),
        .wrCommit(wrCommit), .wrCount(wrCount), .wrReady(wrReady),
        .rdAddress(rdAddress), .rdData(rdData), .rdValid(rdValid),
        .rdCount(rdCount), .rdRelease(rdRelease),
        .wrBank(wrBank), .rdBank(rdBank),
        .errorClear(errorClear), .errorFlags(errorFlags)
    );

    pingpong_stream_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_small (
        .clock(clock), .reset(s_reset),
        .wrAddress(s_wrAddress), .wrEnable(s_wrEnable), .wrData(s_wrData),
        .wrCommit(s_wrCommit), .wrCount(s_wrCount), .wrReady(s_wrReady),
        .rdAddress(s_rdAddress), .rdData(s_rdData), .rdValid(s_rdValid),
        .rdCount(s_rdCount), .rdRelease(s_rdRelease),
        .wrBank(s_wrBank), .rdBank(s_rdBank),
        .errorClear(s_errorClear), .errorFlags(s_errorFlags)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wrAddress = '0; wrEnable = 1'b0; wrData = '0; wrCommit = 1'b0; wrCount = '0;
        rdAddress = '0; rdRelease = 1'b0; errorClear = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic wr_rdy, input logic rd_vld,
                               input logic wr_b, input logic rd_b, input logic [8:0] rd_cnt);
        check({tag, ".wrReady"}, 64'(wrReady), 64'(wr_rdy));
        check({tag, ".rdValid"}, 64'(rdValid), 64'(rd_vld));
        check({tag, ".wrBank"},  64'(wrBank),  64'(wr_b));
        check({tag, ".rdBank"},  64'(rdBank),  64'(rd_b));
        check({tag, ".rdCount"}, 64'(rdCount), 64'(rd_cnt));
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        rdAddress = addr;
        tick();
        check(tag, 64'(rdData), 64'(exp));
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        s_reset = 1'b1;
        s_wrAddress = '0; s_wrEnable = 1'b0; s_wrData = '0; s_wrCommit = 1'b0; s_wrCount = '0;
        s_rdAddress = '0; s_rdRelease = 1'b0; s_errorClear = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_state("reset", 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        check("reset.rdData", 64'(rdData), 64'h0);
        check("reset.errorFlags", 64'(errorFlags), 64'h0);

        // Scenario 1: fill bank 0, commit 256 words, read back
        for (int i = 0; i < 256; i++) begin
            wrEnable = 1'b1; wrAddress = 8'(i); wrData = 32'h100 + 32'(i);
            tick();
        end
        wrEnable = 1'b0;
        wrCommit = 1'b1; wrCount = 9'd256;
        tick();
        wrCommit = 1'b0;
        check_state("commit0", 1'b1, 1'b1, 1'b1, 1'b0, 9'd256);
        for (int i = 0; i < 256; i++) begin
            read_check("bank0_read", 8'(i), 32'h100 + 32'(i));
        end

        // Scenario 2: fill and commit bank 1, then a dropped write + commit
        for (int i = 0; i < 256; i++) begin
            wrEnable = 1'b1; wrAddress = 8'(i); wrData = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        wrEnable = 1'b0;
        wrCommit = 1'b1; wrCount = 9'd256;
        tick();
        check_state("both_full", 1'b0, 1'b1, 1'b0, 1'b0, 9'd256);
        wrEnable = 1'b1; wrAddress = 8'd5; wrData = 32'hDEAD_BEEF;
        wrCommit = 1'b1; wrCount = 9'd7;
        tick();
        wrEnable = 1'b0; wrCommit = 1'b0;
        check("drop.errorFlags", 64'(errorFlags), 64'b011);
        check_state("drop", 1'b0, 1'b1, 1'b0, 1'b0, 9'd256);
        read_check("drop.bank0_addr5", 8'd5, 32'h105);

        errorClear = 1'b1;
        tick();
        errorClear = 1'b0;
        check("clear.errorFlags", 64'(errorFlags), 64'h0);

        // Release bank 0; the read in the release cycle still sees bank 0
        rdRelease = 1'b1; rdAddress = 8'd0;
        tick();
        rdRelease = 1'b0;
        check("release_read_old_bank", 64'(rdData), 64'h100);
        check_state("release0", 1'b1, 1'b1, 1'b0, 1'b1, 9'd256);
        read_check("bank1_addr255", 8'd255, 32'hA5A5_00FF);

        // Scenario 3: refill bank 0; in one cycle write addr 3, commit (count clamped), release bank 1
        for (int i = 0; i < 3; i++) begin
            wrEnable = 1'b1; wrAddress = 8'(i); wrData = 32'h5A5A_0000 + 32'(i);
            tick();
        end
        wrAddress = 8'd3; wrData = 32'h5A5A_0003;
        wrCommit = 1'b1; wrCount = 9'd300;
        rdRelease = 1'b1; rdAddress = 8'd1;
        tick();
        wrEnable = 1'b0; wrCommit = 1'b0; rdRelease = 1'b0;
        check("swap_read_old_bank", 64'(rdData), 64'hA5A5_0001);
        check_state("swap", 1'b1, 1'b1, 1'b1, 1'b0, 9'd256);
        check("swap.errorFlags", 64'(errorFlags), 64'h0);
        read_check("write_in_commit_cycle", 8'd3, 32'h5A5A_0003);
        read_check("bank0_new_addr0", 8'd0, 32'h5A5A_0000);

        // Scenario 4: release bank 0, then illegal release
        rdRelease = 1'b1;
        tick();
        check_state("release_b0", 1'b1, 1'b0, 1'b1, 1'b1, 9'd0);
        tick();
        rdRelease = 1'b0;
        check("bad_release.errorFlags", 64'(errorFlags), 64'b100);
        check_state("bad_release", 1'b1, 1'b0, 1'b1, 1'b1, 9'd0);

        // Zero-count commit
        wrCommit = 1'b1; wrCount = 9'd0;
        tick();
        check_state("commit_zero", 1'b1, 1'b1, 1'b0, 1'b1, 9'd0);
        wrCount = 9'd16;
        tick();
        wrCommit = 1'b0;
        check_state("full_again", 1'b0, 1'b1, 1'b1, 1'b1, 9'd0);
        check("held.errorFlags", 64'(errorFlags), 64'b100);

        // Clear wins over a simultaneous commit error
        errorClear = 1'b1; wrCommit = 1'b1; wrCount = 9'd5;
        tick();
        errorClear = 1'b0; wrCommit = 1'b0;
        check("clear_priority.errorFlags", 64'(errorFlags), 64'h0);
        check("clear_priority.wrBank", 64'(wrBank), 64'h1);

        // Scenario 5: dropped write flags, then reset while both banks are full
        wrEnable = 1'b1; wrAddress = 8'd9; wrData = 32'h1234_5678;
        tick();
        wrEnable = 1'b0;
        check("drop2.errorFlags", 64'(errorFlags), 64'b001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("midreset", 1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
        check("midreset.errorFlags", 64'(errorFlags), 64'h0);
        check("midreset.rdData", 64'(rdData), 64'h0);

        // Small instance: scenario 1 with 16-word banks
        s_reset = 1'b0;
        check("small.reset_wrReady", 64'(s_wrReady), 64'h1);
        check("small.reset_rdValid", 64'(s_rdValid), 64'h0);
        for (int i = 0; i < 16; i++) begin
            s_wrEnable = 1'b1; s_wrAddress = 4'(i); s_wrData = 16'h100 + 16'(i);
            tick();
        end
        s_wrEnable = 1'b0;
        s_wrCommit = 1'b1; s_wrCount = 5'd16;
        tick();
        s_wrCommit = 1'b0;
        check("small.wrBank",  64'(s_wrBank),  64'h1);
        check("small.rdBank",  64'(s_rdBank),  64'h0);
        check("small.rdValid", 64'(s_rdValid), 64'h1);
        check("small.wrReady", 64'(s_wrReady), 64'h1);
        check("small.rdCount", 64'(s_rdCount), 64'd16);
        for (int i = 0; i < 16; i++) begin
            s_rdAddress = 4'(i);
            tick();
            check("small.read", 64'(s_rdData), 64'h100 + 64'(i));
        end
        check("small.errorFlags", 64'(s_errorFlags), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
